frame_capture: RTL
==================

# frame_capture

Receiving end of the pixel flow. It accepts the coordinate-tagged RGB stream that a flow stage emits (`x_out`, `y_out`, `r_out`, `g_out`, `b_out`) and stores each pixel in an on-chip WIDTH×HEIGHT frame buffer. When the frame's final pixel arrives, it stops accepting input and replays the whole frame through a valid/ready stream in scan order. It sits after the last flow stage and feeds display or readback logic.

## Interface
- `WIDTH`, default 32: frame width in pixels; x range is 0..WIDTH-1.
- `HEIGHT`, default 32: frame height in pixels; y range is 0..HEIGHT-1.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: the input pixel is present this cycle.
- `in_ready` output 1: the block accepts input; high only in CAPTURE.
- `x` input 11 (signed): pixel column.
- `y` input 12 (signed): pixel row.
- `r`, `g`, `b` input 8 each: pixel colour.
- `out_valid` output 1: an output pixel is present.
- `out_ready` input 1: the downstream consumer accepts the output pixel.
- `out_x` output 11 (signed), `out_y` output 12 (signed): coordinates of the output pixel.
- `out_rgb` output 24: {r,g,b} of the output pixel.
- `frame_done` output 1: one-cycle pulse when the last pixel is captured.
- `oob_count` output 8: saturating count of dropped out-of-range pixels.

## Operation
- **Storage:** WIDTH*HEIGHT×24-bit memory with synchronous read and no reset.
  - Address = x*HEIGHT + y (column-major): y varies fastest, matching the upstream scan order.
- **States:** CAPTURE and DRAIN.
- **CAPTURE** (`in_ready`=1):
  - On `in_valid`, if 0≤x<WIDTH and 0≤y<HEIGHT, write {r,g,b} to the pixel's address.
  - A negative coordinate or one ≥ the limit drops the pixel and increments `oob_count`, saturating at 255.
  - Writing the same pixel twice keeps the last write.
- **CAPTURE → DRAIN:** taken when an in-range pixel with x=WIDTH-1, y=HEIGHT-1 is written.
  - `frame_done` pulses in the cycle after that write.
  - Pixels never written this frame keep their previous contents. After reset their contents are undefined.
- **DRAIN** (`in_ready`=0):
  - `in_valid` is ignored; the input is not stored and is not counted.
  - Reads addresses 0..N-1 (N=WIDTH*HEIGHT) in order.
  - Presents each pixel with `out_x` = addr/HEIGHT and `out_y` = addr%HEIGHT.
  - `out_valid`, `out_x`, `out_y` and `out_rgb` hold stable while `out_valid`=1 and `out_ready`=0.
  - A one-entry skid/prefetch register sustains one pixel per cycle while `out_ready` is held high.
- **DRAIN → CAPTURE:** taken on the handshake of pixel N-1 (`out_valid`&`out_ready`). `out_valid` falls in the next cycle.
- **Reset** (`rst_n`=0 at an edge), from any state including mid-drain:
  - state = CAPTURE; `out_valid`=0; `out_x`/`out_y`/`out_rgb`=0; `frame_done`=0; `oob_count`=0.
  - `in_ready`=1 from the first cycle after reset.
  - Memory is not cleared.
- **Widths:**
  - Range compare is signed; the sign bit is checked explicitly.
  - The address uses only the low log2 bits of x and y after the range check.
  - `out_x` and `out_y` are zero-extended into their signed widths.

## Timing
- Write latency: 1 cycle (write on the edge where `in_valid` is sampled).
- Let E be the first cycle with state=DRAIN, the edge after the last write.
  - `frame_done`=1 in cycle E only.
  - `out_valid` rises at E+1 with address 0.
- With `out_ready` held at 1:
  - Pixel k is handshaken in cycle E+1+k.
  - The last pixel is handshaken at E+N.
  - `in_ready`=1 at E+N+1.
- When `out_ready` drops:
  - The output holds.
  - When it returns, the next pixel follows with no bubble and none is lost or repeated.
- In CAPTURE, `out_valid` is 0 in every cycle.

## Test plan
- **Full frame, ideal sink:** 32×32 raster with y fastest, rgb = {x,y,x^y}, `out_ready`=1.
  - `frame_done` pulses once.
  - Exactly 1024 outputs in y-fastest order with matching rgb.
  - Drain takes 1024 consecutive cycles starting at E+1; `in_ready` returns at E+1025.
- **Backpressure:** same frame with `out_ready` random at 50%.
  - Output sequence is identical to the ideal-sink case.
  - No pixel changes while stalled with `out_valid` high.
- **Out of range:** inject (-1,0), (32,5), (0,32) and (0,-3) mid-frame.
  - `oob_count`=4 and the drained frame is unaffected.
  - Then inject 300 bad pixels: `oob_count`=255.
- **Input during DRAIN and overwrite:**
  - Pixels offered during drain are not stored and `in_ready`=0.
  - In the next frame, write only (31,31) with rgb 0xABCDEF.
  - The drain shows the old frame except that pixel.
- **Reset mid-drain:** assert `rst_n`=0 at drain pixel 100.
  - Next cycle: `out_valid`=0, `in_ready`=1, `oob_count`=0.
  - A new full frame drains correctly from address 0.

Source files
------------

// File: rtl/frame_capture.sv
// frame_capture: receiving end of the pixel flow.
// Captures a coordinate-tagged RGB stream into a WIDTH x HEIGHT frame buffer
// (column-major, address = x*HEIGHT + y). When the last pixel (WIDTH-1, HEIGHT-1)
// is written, input is closed and the whole frame is replayed in scan order
// through a valid/ready stream. Input opens again after the last replayed pixel.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid, in_ready   - input pixel handshake (in_ready high only while capturing)
//   x, y                 - signed pixel coordinates
//   r, g, b              - pixel colour
//   out_valid, out_ready - output pixel handshake
//   out_x, out_y         - output pixel coordinates (zero-extended)
//   out_rgb              - {r,g,b} of the output pixel
//   frame_done           - one-cycle pulse after the final pixel is captured
//   oob_count            - saturating count of dropped out-of-range pixels
module frame_capture #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [10:0] x,
    input  logic signed [11:0] y,
    input  logic        [7:0]  r,
    input  logic        [7:0]  g,
    input  logic        [7:0]  b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [10:0] out_x,
    output logic signed [11:0] out_y,
    output logic        [23:0] out_rgb,
    output logic               frame_done,
    output logic        [7:0]  oob_count
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [10:0]   X_LIM  = 11'(WIDTH);
    localparam logic [11:0]   Y_LIM  = 12'(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] H_MUL  = AW'(HEIGHT);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);

    typedef enum logic {
        CAPTURE,
        DRAIN
    } state_t;

    state_t state;

    logic [23:0] mem [N];

    // Input side: range check on the full signed value, then index with the
    // low bits only.
    logic          x_ok, y_ok, in_range;
    logic [XW-1:0] xi;
    logic [YW-1:0] yi;
    logic [AW-1:0] wr_addr;
    logic          wr_en, wr_last;

    assign x_ok     = !x[10] && ($unsigned(x) < X_LIM);
    assign y_ok     = !y[11] && ($unsigned(y) < Y_LIM);
    assign in_range = x_ok && y_ok;
    assign xi       = x[XW-1:0];
    assign yi       = y[YW-1:0];
    assign wr_addr  = AW'(xi) * H_MUL + AW'(yi);
    assign wr_en    = rst_n && (state == CAPTURE) && in_valid && in_range;
    assign wr_last  = wr_en && (xi == X_LAST) && (yi == Y_LAST);

    assign in_ready = (state == CAPTURE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {r, g, b};
        end
    end

    // Drain side: rd_* is the next address to fetch. The output register is
    // loaded straight from the synchronous memory read whenever it is empty or
    // being consumed, which gives one pixel per cycle and holds under stall.
    logic [AW-1:0] rd_addr;
    logic [XW-1:0] rd_col;
    logic [YW-1:0] rd_row;
    logic          rd_all;
    logic          out_last;
    logic          advance;
    logic          hs_last;

    assign advance = (state == DRAIN) && !rd_all && (!out_valid || out_ready);
    assign hs_last = out_valid && out_ready && out_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CAPTURE;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_rgb    <= '0;
            frame_done <= 1'b0;
            oob_count  <= '0;
            rd_addr    <= '0;
            rd_col     <= '0;
            rd_row     <= '0;
            rd_all     <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            frame_done <= wr_last;
            case (state)
                CAPTURE: begin
                    if (in_valid && !in_range && (oob_count != 8'hFF)) begin
                        oob_count <= oob_count + 8'd1;
                    end
                    if (wr_last) begin
                        state   <= DRAIN;
                        rd_addr <= '0;
                        rd_col  <= '0;
                        rd_row  <= '0;
                        rd_all  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        out_valid <= 1'b1;
                        out_rgb   <= mem[rd_addr];
                        out_x     <= 11'(rd_col);
                        out_y     <= 12'(rd_row);
                        out_last  <= (rd_addr == A_LAST);
                        if (rd_addr == A_LAST) begin
                            rd_all <= 1'b1;
                        end else begin
                            rd_addr <= rd_addr + AW'(1);
                        end
                        if (rd_row == Y_LAST) begin
                            rd_row <= '0;
                            rd_col <= rd_col + XW'(1);
                        end else begin
                            rd_row <= rd_row + YW'(1);
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (hs_last) begin
                        state <= CAPTURE;
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

endmodule
